// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide units.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam int MUL_ITERS  = 11;
  localparam int RADIX_BITS = 3;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } mul_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_digit_pp.sv
// Radix-8 partial product: 3-bit digit times 32-bit value from x1/x2/x4 terms.
module mul_digit_pp (
  input  logic [2:0]  digit,
  input  logic [31:0] x,
  output logic [34:0] pp
);

  always_comb begin
    pp = ({3'b000, x}      & {35{digit[0]}})
       + ({2'b00, x, 1'b0} & {35{digit[1]}})
       + ({1'b0, x, 2'b00} & {35{digit[2]}});
  end

endmodule

// File: rtl/mul32.sv
// Iterative radix-8 RV32M multiplier: magnitude product, then sign fix and half select.
module mul32
  import muldiv_pkg::*;
#(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  mul_state_e  state, state_nxt;
  logic [31:0] mcand, mplier;
  logic        neg, op_mul;
  logic [63:0] prod, prod_nxt, fixed;
  logic [3:0]  cnt, k;
  logic [5:0]  shamt;
  logic [34:0] pp;
  logic        rs1_signed, rs2_signed, zero_op;
  logic [31:0] result_d;
  logic        busy_d, done_d;

  assign rs1_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign rs2_signed = (op == OP_MULH);
  assign zero_op    = EARLY_ZERO && ((rs1 == '0) || (rs2 == '0));

  mul_digit_pp u_pp (
    .digit (mplier[2:0]),
    .x     (mcand),
    .pp    (pp)
  );

  // mplier shifts right each iteration, so its low digit is always digit k.
  assign k        = 4'(MUL_ITERS) - cnt;
  assign shamt    = {1'b0, k, 1'b0} + {2'b00, k};
  assign prod_nxt = prod + (64'(pp) << shamt);
  assign fixed    = neg ? (~prod + 64'd1) : prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (cnt == 4'd1) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    case (state)
      IDLE: if (start) busy_d = 1'b1;
      FIX: begin
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = op_mul ? fixed[31:0] : fixed[63:32];
      end
      default: ;
    endcase
  end

  // Zero operands take a single all-zero iteration, giving done two edges after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      op_mul <= 1'b0;
      prod   <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      result <= result_d;
      busy   <= busy_d;
      done   <= done_d;
      case (state)
        IDLE: if (start) begin
          mcand  <= zero_op ? '0 : mag32(rs1, rs1_signed);
          mplier <= zero_op ? '0 : mag32(rs2, rs2_signed);
          neg    <= (rs1_signed & rs1[31]) ^ (rs2_signed & rs2[31]);
          op_mul <= (op == OP_MUL);
          prod   <= '0;
          cnt    <= zero_op ? 4'd1 : 4'(MUL_ITERS);
        end
        ITER: begin
          prod   <= prod_nxt;
          mplier <= mplier >> RADIX_BITS;
          cnt    <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32.sv
// Self-checking bench for mul32 against a 64-bit arithmetic reference.
module tb_mul32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start0 = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [31:0] result, result0;
  logic        busy, busy0, done, done0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul32 #(.EARLY_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .result(result), .busy(busy), .done(done)
  );

  mul32 #(.EARLY_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .rs1(rs1), .rs2(rs2),
    .result(result0), .busy(busy0), .done(done0)
  );

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (o == 2'b01 || o == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (o == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(sa * sb);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one op (called right after an edge), then wait for done with a bounded budget.
  task automatic run(input string name, input bit use0, input logic [1:0] o,
                     input logic [31:0] a, input logic [31:0] b, input int lat);
    logic [31:0] exp;
    int cyc;
    bit seen;
    exp = ref_mul(o, a, b);
    op = o; rs1 = a; rs2 = b;
    if (use0) start0 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start0 = 1'b0;
    rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
    check({name, "_busy_accept"}, use0 ? busy0 : busy, 1);
    cyc = 0; seen = 0;
    while (cyc < 40 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (use0 ? done0 : done) seen = 1;
      else if (!(use0 ? busy0 : busy)) check({name, "_busy_mid"}, 0, 1);
    end
    check({name, "_latency"}, cyc, lat);
    check({name, "_result"}, use0 ? result0 : result, exp);
    check({name, "_busy_done"}, use0 ? busy0 : busy, 0);
  endtask

  initial begin
    int cyc, pulses;
    logic [31:0] a, b;
    logic [1:0]  o;

    #3;
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    run("mul_7x6", 0, 2'b00, 32'd7, 32'd6, 12);
    run("mul_m3x5", 0, 2'b00, 32'hFFFFFFFD, 32'd5, 12);
    run("mulh_m3x5", 0, 2'b01, 32'hFFFFFFFD, 32'd5, 12);
    check("ref_mulh_m3x5", ref_mul(2'b01, 32'hFFFFFFFD, 32'd5), 32'hFFFFFFFF);
    run("mulh_min", 0, 2'b01, 32'h80000000, 32'h80000000, 12);
    check("ref_mulh_min", ref_mul(2'b01, 32'h80000000, 32'h80000000), 32'h40000000);
    run("mulhu_max", 0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 12);
    run("mulhsu_max", 0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 12);
    check("ref_mulhsu_max", ref_mul(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);

    run("ez_zero", 0, 2'b11, 32'd0, 32'h12345678, 2);
    run("noez_zero", 1, 2'b11, 32'd0, 32'h12345678, 12);

    // Second start mid-operation must be ignored.
    op = 2'b00; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; op = 2'b11; rs1 = 32'hDEADBEEF; rs2 = 32'hCAFEF00D; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 5;
    while (cyc < 40 && !done) begin @(posedge clk); #1; cyc++; end
    check("ignore_latency", cyc, 12);
    check("ignore_result", result, 32'd3000);
    @(posedge clk); #1;
    check("ignore_no_relaunch", busy, 0);

    // Back-to-back: start is raised while done is high.
    run("b2b_first", 0, 2'b00, 32'd11, 32'd13, 12);
    check("b2b_done_high", done, 1);
    run("b2b_second", 0, 2'b01, 32'hFFFF0000, 32'h00012345, 12);

    // Reset mid-operation aborts without a done pulse.
    op = 2'b00; rs1 = 32'd55; rs2 = 32'd77; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (16) begin @(posedge clk); #1; if (done) pulses++; end
    check("abort_no_done", pulses, 0);
    run("post_abort", 0, 2'b00, 32'h00010000, 32'h00010000, 12);

    // Randomised ops, with occasional zero operands to exercise the shortcut.
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      o = 2'($urandom);
      run("rand", 0, o, a, b, (a == 0 || b == 0) ? 2 : 12);
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'($urandom);
      run("rand_noez", 1, 2'($urandom), a, 32'd0, 12);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
